multicycle_sequencer: RTL and testbench
=======================================

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter COUNT_W, default 32, the width of the retired-instruction and cycle counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, begin execution from IDLE.
REQ-005 SHALL have port opcode, input, 3, IR[24:22]: add=000, nor=001, lw=010, sw=011, beq=100, jalr=101, halt=110, noop=111.
REQ-006 SHALL have port alu_eq, input, 1, regA==regB compare result from the datapath.
REQ-007 SHALL have port mem_ready, input, 1, memory completion for the current mem_req.
REQ-008 SHALL have ports mem_req (1), mem_we (1) and mem_addr_sel (1: 0=PC, 1=ALU), all outputs.
REQ-009 SHALL have ports ir_write (1), pc_write (1) and pc_src (2: 00=PC+1, 01=branch target, 10=regA), all outputs.
REQ-010 SHALL have ports reg_write (1), reg_dst (1: 1=destReg, 0=regB) and wb_sel (2: 00=ALU, 01=MEM, 10=PC), all outputs.
REQ-011 SHALL have ports alu_srcB (1: 1=regB, 0=offset) and alu_op (2: 00=add, 01=nor, 10=eq), both outputs.
REQ-012 SHALL have port halted (1) and ports instr_count and cycle_count (COUNT_W each), all outputs.

Function
REQ-013 SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALTED.
REQ-014 In IDLE, start=1 SHALL go to FETCH next cycle; in any other state, start SHALL be ignored.
REQ-015 In FETCH, mem_req=1 and mem_addr_sel=0 SHALL hold until mem_ready=1; in the mem_ready cycle, ir_write=1, pc_write=1 and pc_src=00 SHALL assert, then the FSM SHALL go to DECODE.
REQ-016 In DECODE, the FSM SHALL latch opcode into op_q; opcode SHALL be ignored in every other state.
REQ-017 From DECODE: halt->HALTED; noop->FETCH; all other opcodes->EXEC.
REQ-018 In EXEC, add/nor SHALL drive alu_srcB=1 with alu_op=00/01 respectively, then go to WB.
REQ-019 In EXEC, lw/sw SHALL drive alu_srcB=0, alu_op=00, then go to MEM.
REQ-020 In EXEC, beq SHALL drive alu_op=10, alu_srcB=1, and assert pc_write=1 with pc_src=01 only if alu_eq=1, then go to FETCH.
REQ-021 In EXEC, jalr SHALL drive reg_write=1, reg_dst=0, wb_sel=10, pc_write=1 and pc_src=10 in the same cycle, then go to FETCH.
REQ-022 In MEM, mem_req=1 and mem_addr_sel=1 SHALL hold, with mem_we=1 for sw, until mem_ready; then lw->WB and sw->FETCH.
REQ-023 In WB, reg_write=1 SHALL assert; add/nor SHALL use reg_dst=1, wb_sel=00; lw SHALL use reg_dst=0, wb_sel=01; the FSM SHALL then go to FETCH.
REQ-024 HALTED SHALL be terminal: halted=1, all other strobes 0, exit only by reset.
REQ-025 A write strobe (ir_write, pc_write, reg_write, mem_we) SHALL be active at most one cycle per instruction, except mem_we, which SHALL remain high through the MEM wait.
REQ-026 mem_ready while mem_req=0 SHALL be ignored.
REQ-027 instr_count SHALL increment by 1 on each instruction's final cycle (leaving WB, leaving MEM for sw, leaving EXEC for beq/jalr, leaving DECODE for noop/halt) and SHALL saturate at all-ones.
REQ-028 cycle_count SHALL increment every cycle the state is neither IDLE nor HALTED, and SHALL saturate at all-ones.
REQ-029 Outputs SHALL be combinational from state, op_q, mem_ready and alu_eq, with no additional latency.

Reset
REQ-030 reset SHALL force state IDLE, op_q=111 and both counters to 0 immediately, without waiting for clk.
REQ-031 While reset is high or the state is IDLE, every strobe and select output SHALL be 0 and halted SHALL be 0.
REQ-032 On reset mid-transaction, mem_req SHALL drop immediately; the memory shall tolerate the abandoned request.

Structure
REQ-033 Package lc2k_pkg SHALL hold the opcode constants, the state enum and the pc_src/wb_sel/alu_op encodings.
REQ-034 Sub-module sat_counter (parameter W, inputs inc and clr) SHALL be instantiated twice, once for each counter.

Verification
REQ-035 Test add: with mem_ready always 1, start then add, the bench SHALL see FETCH-DECODE-EXEC-WB in 4 cycles, reg_write=1 with reg_dst=1 and wb_sel=00 in WB, and instr_count=1.
REQ-036 Test lw with a fetch wait: with mem_ready low for 3 cycles in FETCH, mem_req SHALL be held for 4 cycles and ir_write SHALL pulse once; lw SHALL then take 5 states with wb_sel=01.
REQ-037 Test beq: with alu_eq=1, pc_write=1 and pc_src=01 SHALL occur in EXEC; with alu_eq=0, pc_write SHALL stay 0 in EXEC; both cases SHALL increment instr_count.
REQ-038 Test jalr: EXEC SHALL show reg_write=1, wb_sel=10, pc_src=10 and pc_write=1 in a single cycle, with the next state FETCH.
REQ-039 Test halt: after noop then halt, halted=1 and instr_count=2; the counters SHALL freeze and start SHALL be ignored.
REQ-040 Test reset in MEM: reset during a sw MEM wait SHALL drop mem_req and mem_we and zero the counters asynchronously; start SHALL then restart from FETCH.

Source files
------------

// File: rtl/lc2k_pkg.sv
// Shared encodings for the LC-2K multicycle control sequencer:
// opcodes, FSM states and datapath select codes.
package lc2k_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NOR  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JALR = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_NOOP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_REGA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_NOR = 2'b01;
  localparam logic [1:0] ALU_EQ  = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async reset and sync clear;
// sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // count up on inc, hold once every bit is set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// LC-2K multicycle control FSM: fetch/decode/exec/mem/wb
// strobes plus saturating retired-instruction and cycle counters.
module multicycle_sequencer
  import lc2k_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         opcode,
  input  logic               alu_eq,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               reg_dst,
  output logic [1:0]         wb_sel,
  output logic               alu_srcB,
  output logic [1:0]         alu_op,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count,
  output logic [COUNT_W-1:0] cycle_count
);

  state_t     state;
  state_t     next;
  logic [2:0] op_q;
  logic       retire;
  logic       busy;

  // state register; opcode is captured only while decoding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= OP_NOOP;
    end else begin
      state <= next;
      if (state == S_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  // next state, strobes and the retire pulse
  always_comb begin
    next         = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_INC;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    wb_sel       = WB_ALU;
    alu_srcB     = 1'b0;
    alu_op       = ALU_ADD;
    halted       = 1'b0;
    retire       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_INC;
          next     = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_HALT: begin
            next   = S_HALTED;
            retire = 1'b1;
          end
          OP_NOOP: begin
            next   = S_FETCH;
            retire = 1'b1;
          end
          default: next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        next = S_FETCH;
        case (op_q)
          OP_ADD, OP_NOR: begin
            alu_srcB = 1'b1;
            alu_op   = (op_q == OP_NOR) ? ALU_NOR : ALU_ADD;
            next     = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_srcB = 1'b0;
            alu_op   = ALU_ADD;
            next     = S_MEM;
          end
          OP_BEQ: begin
            alu_srcB = 1'b1;
            alu_op   = ALU_EQ;
            retire   = 1'b1;
            if (alu_eq) begin
              pc_write = 1'b1;
              pc_src   = PC_BR;
            end
          end
          OP_JALR: begin
            reg_write = 1'b1;
            reg_dst   = 1'b0;
            wb_sel    = WB_PC;
            pc_write  = 1'b1;
            pc_src    = PC_REGA;
            retire    = 1'b1;
          end
          default: retire = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            next   = S_FETCH;
            retire = 1'b1;
          end else begin
            next = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        next      = S_FETCH;
        if (op_q == OP_LW) begin
          reg_dst = 1'b0;
          wb_sel  = WB_MEM;
        end else begin
          reg_dst = 1'b1;
          wb_sel  = WB_ALU;
        end
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      default: next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_HALTED);

  sat_counter #(.W(COUNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .clr   (1'b0),
    .count (instr_count)
  );

  sat_counter #(.W(COUNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (busy),
    .clr   (1'b0),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction strobe
// statistics against an instruction-level timing model.
module tb_multicycle_sequencer;

  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] NOR  = 3'd1;
  localparam logic [2:0] LW   = 3'd2;
  localparam logic [2:0] SW   = 3'd3;
  localparam logic [2:0] BEQ  = 3'd4;
  localparam logic [2:0] JALR = 3'd5;
  localparam logic [2:0] HALT = 3'd6;
  localparam logic [2:0] NOOP = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    opcode;
  logic          alu_eq;
  logic          mem_ready;
  logic          mem_req;
  logic          mem_we;
  logic          mem_addr_sel;
  logic          ir_write;
  logic          pc_write;
  logic [1:0]    pc_src;
  logic          reg_write;
  logic          reg_dst;
  logic [1:0]    wb_sel;
  logic          alu_srcB;
  logic [1:0]    alu_op;
  logic          halted;
  logic [CW-1:0] instr_count;
  logic [CW-1:0] cycle_count;
  logic [14:0]   outs;

  always #5 clk = ~clk;

  multicycle_sequencer #(.COUNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .opcode       (opcode),
    .alu_eq       (alu_eq),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .wb_sel       (wb_sel),
    .alu_srcB     (alu_srcB),
    .alu_op       (alu_op),
    .halted       (halted),
    .instr_count  (instr_count),
    .cycle_count  (cycle_count)
  );

  assign outs = {mem_req, mem_we, mem_addr_sel, ir_write,
                 pc_write, pc_src, reg_write, reg_dst,
                 wb_sel, alu_srcB, alu_op, halted};

  int total = 0;
  int bad   = 0;
  int m_ic  = 0;
  int m_cc  = 0;

  typedef struct {
    logic [2:0] op;
    logic       eq;
    int         fw;
    int         mw;
    int         cyc;
    int         regw;
    int         pcw;
  } vec_t;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int m_cycles(input logic [2:0] op,
                                  input int fw, input int mw);
    int n;
    n = fw + 2;
    if (op == HALT || op == NOOP) return n;
    n += 1;
    if (op == LW || op == SW) n += mw + 1;
    if (op == ADD || op == NOR || op == LW) n += 1;
    return n;
  endfunction

  function automatic int m_regw(input logic [2:0] op);
    return (op == ADD || op == NOR || op == LW || op == JALR) ? 1 : 0;
  endfunction

  function automatic int m_pcw(input logic [2:0] op, input logic eq);
    return 1 + ((op == BEQ && eq) ? 1 : 0) + ((op == JALR) ? 1 : 0);
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Run one instruction starting in FETCH for a model-predicted
  // number of cycles, then compare strobe statistics.
  task automatic run(input logic [2:0] op, input logic eq,
                     input int fw, input int mw, input int cyc,
                     input int regw, input int pcw);
    int fc, mc, n_req, n_ir, n_pcw, n_regw, n_we, n_srcb;
    int exp_we, exp_req, exp_srcb;
    logic [2:0] mask, exp_mask;
    logic [1:0] wbs, alu_seen, exp_wbs, exp_alu;
    logic rdst, exp_rdst;
    fc = 0; mc = 0; n_req = 0; n_ir = 0; n_pcw = 0;
    n_regw = 0; n_we = 0; n_srcb = 0;
    mask = '0; wbs = 2'b11; alu_seen = 2'b11; rdst = 1'bx;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      start  = 1'($urandom);
      opcode = (i == fw + 1) ? op : 3'($urandom);
      alu_eq = eq;
      if (mem_req) begin
        if (!mem_addr_sel) begin
          mem_ready = (fc >= fw);
          fc++;
        end else begin
          mem_ready = (mc >= mw);
          mc++;
        end
      end else begin
        mem_ready = 1'($urandom);
      end
      #1;
      if (mem_req) n_req++;
      if (ir_write) n_ir++;
      if (mem_we) n_we++;
      if (pc_write) begin
        n_pcw++;
        mask = mask | 3'(1 << pc_src);
      end
      if (reg_write) begin
        n_regw++;
        wbs  = wb_sel;
        rdst = reg_dst;
      end
      if (alu_srcB) begin
        n_srcb++;
        alu_seen = alu_op;
      end
    end
    @(posedge clk);
    #1;
    m_ic = sat(m_ic + 1);
    m_cc = sat(m_cc + cyc);
    exp_mask = 3'b001;
    if (op == BEQ && eq) exp_mask = 3'b011;
    if (op == JALR) exp_mask = 3'b101;
    exp_we   = (op == SW) ? mw + 1 : 0;
    exp_req  = fw + 1 + ((op == LW || op == SW) ? mw + 1 : 0);
    exp_srcb = (op == ADD || op == NOR || op == BEQ) ? 1 : 0;
    exp_alu  = (op == NOR) ? 2'b01 : (op == BEQ) ? 2'b10 : 2'b00;
    exp_wbs  = (op == LW) ? 2'b01 : (op == JALR) ? 2'b10 : 2'b00;
    exp_rdst = (op == ADD || op == NOR);
    chk("ir_write pulses", n_ir, 1);
    chk("pc_write pulses", n_pcw, pcw);
    chk("pc_src mask", mask, exp_mask);
    chk("reg_write pulses", n_regw, regw);
    if (regw > 0) begin
      chk("wb_sel", wbs, exp_wbs);
      chk("reg_dst", rdst, exp_rdst);
    end
    chk("mem_we cycles", n_we, exp_we);
    chk("mem_req cycles", n_req, exp_req);
    chk("alu_srcB cycles", n_srcb, exp_srcb);
    if (exp_srcb > 0) chk("alu_op", alu_seen, exp_alu);
    chk("instr_count", instr_count, m_ic);
    chk("cycle_count", cycle_count, m_cc);
    if (op == HALT) begin
      chk("halted outs", outs, 15'd1);
    end else begin
      chk("back in fetch", {mem_req, mem_addr_sel}, 2'b10);
    end
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{ADD,  1'b0, 0, 0, 4, 1, 1};
    tbl[1] = '{NOR,  1'b0, 1, 0, 5, 1, 1};
    tbl[2] = '{LW,   1'b0, 3, 0, 8, 1, 1};
    tbl[3] = '{SW,   1'b0, 0, 2, 6, 0, 1};
    tbl[4] = '{BEQ,  1'b1, 0, 0, 3, 0, 2};
    tbl[5] = '{BEQ,  1'b0, 0, 0, 3, 0, 1};
    tbl[6] = '{JALR, 1'b0, 0, 0, 3, 1, 2};
    tbl[7] = '{NOOP, 1'b0, 0, 0, 2, 0, 1};
    tbl[8] = '{LW,   1'b1, 0, 1, 6, 1, 1};

    reset = 1'b1; start = 1'b0; opcode = 3'd0;
    alu_eq = 1'b0; mem_ready = 1'b1;
    #3;
    chk("reset outs", outs, 15'd0);
    chk("reset instr_count", instr_count, 0);
    chk("reset cycle_count", cycle_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("idle outs", outs, 15'd0);
    chk("idle cycle_count", cycle_count, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start to fetch", {mem_req, mem_addr_sel}, 2'b10);

    for (int k = 0; k < 9; k++) begin
      run(tbl[k].op, tbl[k].eq, tbl[k].fw, tbl[k].mw,
          tbl[k].cyc, tbl[k].regw, tbl[k].pcw);
    end

    for (int k = 0; k < 70; k++) begin
      logic [2:0] op;
      logic eq;
      int fw, mw;
      op = 3'($urandom_range(0, 6));
      if (op == HALT) op = NOOP;
      eq = 1'($urandom);
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      run(op, eq, fw, mw, m_cycles(op, fw, mw),
          m_regw(op), m_pcw(op, eq));
    end

    opcode = SW; start = 1'b0; alu_eq = 1'b0;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("sw mem_req in mem", mem_req, 1);
    chk("sw mem_we in mem", mem_we, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset mem_req", mem_req, 0);
    chk("async reset mem_we", mem_we, 0);
    chk("async reset instr_count", instr_count, 0);
    chk("async reset cycle_count", cycle_count, 0);
    chk("async reset outs", outs, 15'd0);
    @(negedge clk);
    reset = 1'b0;
    m_ic = 0;
    m_cc = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart to fetch", {mem_req, mem_addr_sel}, 2'b10);
    chk("restart cycle_count", cycle_count, 0);

    run(NOOP, 1'b0, 1, 0, m_cycles(NOOP, 1, 0), 0, 1);
    run(HALT, 1'b0, 0, 0, m_cycles(HALT, 0, 0), 0, 1);
    chk("halt instr_count is 2", instr_count, 2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b1;
      mem_ready = 1'($urandom);
      opcode = 3'($urandom);
      #1;
      chk("halted frozen outs", outs, 15'd1);
    end
    chk("halted instr_count", instr_count, m_ic);
    chk("halted cycle_count", cycle_count, m_cc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
